// File: rtl/axis_crc_append.sv
// Byte-wide AXI4-Stream pass-through that appends a configurable MSB-first CRC
// after each packet's last byte, most-significant CRC byte first.
module axis_crc_append #(
  parameter int unsigned      CRC_W  = 24,
  parameter logic [CRC_W-1:0] POLY   = 24'h864CFB,
  parameter logic [CRC_W-1:0] INIT   = 24'hB704CE,
  parameter logic [CRC_W-1:0] XOROUT = 24'h000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic [CRC_W-1:0] crc_value,
  output logic             crc_done,
  output logic             fsm_state
);

  // Handshake: a byte moves on either side only in a cycle where valid and
  // ready are both high; valid never waits on ready, and a stalled output
  // byte (m_tvalid && !m_tready) holds m_tdata/m_tlast unchanged.

  localparam int unsigned NBYTES = CRC_W / 8;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

  typedef enum logic {PASS = 1'b0, APPEND = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CRC_W-1:0] crc_next;
  logic [CRC_W-1:0] final_crc;
  logic             out_ready;
  logic             accept;
  logic             last_accept;
  logic             crc_byte_load;

  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c,
                                                input logic [7:0] d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[CRC_W-1] ^ d[b];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  assign crc_next  = crc_byte(crc_q, s_tdata);
  assign final_crc = crc_next ^ XOROUT;
  // The output register may take a new byte when it is empty or draining now.
  assign out_ready = !m_tvalid || m_tready;
  assign fsm_state = (state_q == APPEND);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= PASS;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    s_tready      = 1'b0;
    accept        = 1'b0;
    last_accept   = 1'b0;
    crc_byte_load = 1'b0;
    case (state_q)
      PASS: begin
        s_tready = out_ready;
        accept   = s_tvalid && out_ready;
        if (accept && s_tlast) begin
          last_accept = 1'b1;
          state_d     = APPEND;
        end
      end
      APPEND: begin
        crc_byte_load = out_ready;
        if (out_ready && cnt_q == CNT_W'(1)) state_d = PASS;
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q     <= INIT;
      shift_q   <= '0;
      cnt_q     <= '0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      crc_value <= '0;
      crc_done  <= 1'b0;
    end else begin
      crc_done <= last_accept;
      if (accept) begin
        m_tdata  <= s_tdata;
        m_tvalid <= 1'b1;
        m_tlast  <= 1'b0;
        if (s_tlast) begin
          shift_q   <= final_crc;
          crc_value <= final_crc;
          cnt_q     <= CNT_W'(NBYTES);
          crc_q     <= INIT;
        end else begin
          crc_q <= crc_next;
        end
      end else if (crc_byte_load) begin
        m_tdata  <= shift_q[CRC_W-1 -: 8];
        m_tvalid <= 1'b1;
        m_tlast  <= (cnt_q == CNT_W'(1));
        shift_q  <= shift_q << 8;
        cnt_q    <= cnt_q - CNT_W'(1);
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_crc_append.sv
// Directed and randomized bench for axis_crc_append: a 24-bit and a 32-bit
// instance share the stimulus; the reference CRC is polynomial long division.
module tb_axis_crc_append;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals and DUTs ----------------
  logic [7:0] s_tdata  = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tlast  = 1'b0;
  logic       m_tready = 1'b1;
  logic       sel32    = 1'b0;
  int         ready_mode = 0;

  logic        s_tvalid_a, s_tready_a, m_tvalid_a, m_tlast_a, crc_done_a, fsm_a;
  logic [7:0]  m_tdata_a;
  logic [23:0] crc_value_a;
  logic        s_tvalid_b, s_tready_b, m_tvalid_b, m_tlast_b, crc_done_b, fsm_b;
  logic [7:0]  m_tdata_b;
  logic [31:0] crc_value_b;

  logic        s_tready_s, m_tvalid_s, m_tlast_s, crc_done_s, fsm_s;
  logic [7:0]  m_tdata_s;
  logic [31:0] crc_value_s;

  assign s_tvalid_a  = s_tvalid && !sel32;
  assign s_tvalid_b  = s_tvalid && sel32;
  assign s_tready_s  = sel32 ? s_tready_b : s_tready_a;
  assign m_tvalid_s  = sel32 ? m_tvalid_b : m_tvalid_a;
  assign m_tlast_s   = sel32 ? m_tlast_b : m_tlast_a;
  assign m_tdata_s   = sel32 ? m_tdata_b : m_tdata_a;
  assign crc_done_s  = sel32 ? crc_done_b : crc_done_a;
  assign crc_value_s = sel32 ? crc_value_b : {8'h00, crc_value_a};
  assign fsm_s       = sel32 ? fsm_b : fsm_a;

  axis_crc_append dut (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid_a), .s_tlast(s_tlast), .s_tready(s_tready_a),
    .m_tdata(m_tdata_a), .m_tvalid(m_tvalid_a), .m_tlast(m_tlast_a), .m_tready(m_tready),
    .crc_value(crc_value_a), .crc_done(crc_done_a), .fsm_state(fsm_a)
  );

  axis_crc_append #(
    .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOROUT(32'h00000000)
  ) dut32 (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid_b), .s_tlast(s_tlast), .s_tready(s_tready_b),
    .m_tdata(m_tdata_b), .m_tvalid(m_tvalid_b), .m_tlast(m_tlast_b), .m_tready(m_tready),
    .crc_value(crc_value_b), .crc_done(crc_done_b), .fsm_state(fsm_b)
  );

  always begin
    @(posedge clk);
    #1;
    m_tready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(1));
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference CRC: XOR the seed into the first W bits of the zero-augmented
  // message, then take the remainder modulo x^W + POLY by long division.
  function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input logic [31:0] xorout,
                                          input logic [7:0] p[$]);
    bit          s[$];
    int          n;
    logic [32:0] gen;
    logic [31:0] r;
    foreach (p[i]) for (int b = 7; b >= 0; b--) s.push_back(p[i][b]);
    n = s.size();
    for (int i = 0; i < w; i++) s.push_back(1'b0);
    for (int i = 0; i < w; i++) s[i] = s[i] ^ init[w-1-i];
    gen = (33'd1 << w) | {1'b0, poly};
    for (int i = 0; i < n; i++)
      if (s[i]) for (int j = 0; j <= w; j++) s[i+j] = s[i+j] ^ gen[w-j];
    r = '0;
    for (int i = 0; i < w; i++) r = {r[30:0], s[n+i]};
    return r ^ xorout;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [8:0]  exp_q[$];
  logic [31:0] crc_exp_q[$];
  int          out_len_q[$];
  int          tlast_cnt = 0, done_cnt = 0, cur_len = 0;
  int          first_out_cyc = 0, tlast_cyc = 0;
  bit          in_pkt = 0, prev_stall = 0;
  logic [8:0]  prev_out = '0;
  logic [8:0]  exp_b;
  logic [31:0] exp_c;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 0;
      in_pkt     = 0;
      cur_len    = 0;
    end else begin
      if (prev_stall) chk("stall_hold", {m_tvalid_s, m_tlast_s, m_tdata_s}, {1'b1, prev_out});
      if (m_tvalid_s && m_tready) begin
        if (!in_pkt) begin
          first_out_cyc = cyc;
          in_pkt = 1;
        end
        cur_len++;
        chk("out_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          chk("out_byte", {m_tlast_s, m_tdata_s}, exp_b);
        end
        if (m_tlast_s) begin
          tlast_cnt++;
          tlast_cyc = cyc;
          out_len_q.push_back(cur_len);
          cur_len = 0;
          in_pkt  = 0;
        end
      end
      prev_stall = m_tvalid_s && !m_tready;
      prev_out   = {m_tlast_s, m_tdata_s};
      if (crc_done_s) begin
        done_cnt++;
        chk("crc_done_expected", crc_exp_q.size() > 0, 1'b1);
        if (crc_exp_q.size() > 0) begin
          exp_c = crc_exp_q.pop_front();
          chk("crc_value", crc_value_s, exp_c);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int first_acc_cyc = 0, last_acc_cyc = 0, pkts_sent = 0, sends = 0;

  task automatic send_pkt(input logic [7:0] p[$], input int gap_pct, input bit hold);
    int          n, w, nb;
    bit          acc;
    logic [31:0] c, t;
    for (int i = 0; i < p.size(); i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = p[i];
      s_tlast  = (i == p.size() - 1);
      acc = 0;
      n   = 0;
      while (!acc && n < 3000) begin
        @(negedge clk);
        if (s_tready_s) begin
          acc = 1;
          exp_q.push_back({1'b0, p[i]});
          if (i == 0) first_acc_cyc = cyc;
          if (i == p.size() - 1) last_acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) begin
        chk("accept_timeout", acc, 1'b1);
        break;
      end
    end
    w  = sel32 ? 32 : 24;
    nb = w / 8;
    c  = sel32 ? ref_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'h0, p)
               : ref_crc(24, 32'h864CFB, 32'hB704CE, 32'h0, p);
    for (int k = 0; k < nb; k++) begin
      t = c >> (8 * (nb - 1 - k));
      exp_q.push_back({1'(k == nb - 1), t[7:0]});
    end
    crc_exp_q.push_back(c);
    pkts_sent++;
    sends++;
    if (!hold) begin
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || in_pkt) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] ascii[$];
  logic [7:0] one[$];
  logic [7:0] rp[$];
  int         l1, d0, tl0, len;

  initial begin
    for (int i = 0; i < 9; i++) ascii.push_back(8'(8'h31 + i));
    one.push_back(8'h31);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_tvalid", m_tvalid_s, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("reset_m_tdata", m_tdata_s, 8'h00);
    chk("reset_m_tlast", m_tlast_s, 1'b0);
    chk("reset_crc_value", crc_value_s, 32'h0);
    chk("reset_crc_done", crc_done_s, 1'b0);
    chk("reset_s_tready", s_tready_s, 1'b1);
    chk("reset_fsm", fsm_s, 1'b0);
    chk("model_24", ref_crc(24, 32'h864CFB, 32'hB704CE, 32'h0, ascii), 32'h0021CF02);
    @(posedge clk);
    #1;

    // "123456789", default CRC-24
    d0 = done_cnt;
    send_pkt(ascii, 0, 0);
    drain();
    chk("c24_crc_value", crc_value_s, 32'h0021CF02);
    chk("c24_latency", first_out_cyc, first_acc_cyc + 1);
    chk("c24_out_cycles", tlast_cyc, first_acc_cyc + 12);
    chk("c24_out_len", out_len_q[$], 12);
    chk("c24_done_pulses", done_cnt - d0, 1);

    // "123456789", CRC-32/MPEG-2 instance
    sel32 = 1'b1;
    #1;
    send_pkt(ascii, 0, 0);
    drain();
    chk("c32_crc_value", crc_value_s, 32'h0376E6E7);
    chk("c32_out_len", out_len_q[$], 13);
    sel32 = 1'b0;
    #1;

    // back-to-back packets with s_tvalid held high
    d0 = done_cnt;
    send_pkt(ascii, 0, 1);
    l1 = last_acc_cyc;
    send_pkt(ascii, 0, 0);
    chk("b2b_next_accept", first_acc_cyc, l1 + 4);
    drain();
    chk("b2b_crc_value", crc_value_s, 32'h0021CF02);
    chk("b2b_done_pulses", done_cnt - d0, 2);

    // single-byte packet then "123456789"
    out_len_q.delete();
    send_pkt(one, 0, 1);
    send_pkt(ascii, 0, 0);
    drain();
    chk("single_pkt_count", out_len_q.size(), 2);
    chk("single_len", out_len_q[0], 4);
    chk("single_next_crc", crc_value_s, 32'h0021CF02);

    // asynchronous reset during APPEND
    tl0 = tlast_cnt;
    send_pkt(ascii, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_reset_fsm", fsm_s, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("areset_m_tvalid", m_tvalid_s, 1'b0);
    chk("areset_m_tlast", m_tlast_s, 1'b0);
    chk("areset_fsm", fsm_s, 1'b0);
    chk("areset_crc_value", crc_value_s, 32'h0);
    exp_q.delete();
    crc_exp_q.delete();
    pkts_sent--;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("areset_no_tlast", tlast_cnt, tl0);
    send_pkt(ascii, 0, 0);
    drain();
    chk("areset_next_crc", crc_value_s, 32'h0021CF02);
    chk("areset_next_tlast", tlast_cnt, tl0 + 1);

    // randomized packets, random gaps and back-pressure
    ready_mode = 1;
    for (int pk = 0; pk < 200; pk++) begin
      rp.delete();
      len = $urandom_range(1, 64);
      for (int i = 0; i < len; i++) rp.push_back(8'($urandom_range(255)));
      send_pkt(rp, 30, 0);
    end
    drain();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    chk("final_tlast_count", tlast_cnt, pkts_sent);
    chk("final_done_count", done_cnt, sends);
    chk("final_crc_queue", crc_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
